// File: rtl/array_combine_8x8_if.sv
// array_combine_8x8_if: operand/result bundle for the 8x8 carry-disregard multiplier.
interface array_combine_8x8_if;
  logic        in_valid;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        out_valid;
  logic [16:0] R;
  modport master (output in_valid, A, B, input out_valid, R);
  modport slave  (input in_valid, A, B, output out_valid, R);
endinterface

// File: rtl/array_combine_8x8.sv
// array_combine_8x8: registered 8x8 approximate multiplier (carry-disregard OR combine of four 4x4 arrays).
// Define ARRAY_COMBINE_EXACT_EN to restore the full carry chain and get the exact product.
module array_mul4x4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);
  logic [3:0][3:0] w_pp;
  logic [3:0][4:0] w_row;
  genvar i, j;
  for (i = 0; i < 4; i++) begin : g_pp
    assign w_pp[i] = i_a & {4{i_b[i]}};
  end
  assign w_row[0] = {1'b0, w_pp[0]};
  // each row adds the next shifted AND row to the upper bits of the previous sum
  for (i = 1; i < 4; i++) begin : g_row
    logic [4:0] w_c;
    assign w_c[0] = 1'b0;
    for (j = 0; j < 4; j++) begin : g_fa
      logic w_x, w_y;
      assign w_x = w_pp[i][j];
      assign w_y = w_row[i-1][j+1];
      assign w_row[i][j] = w_x ^ w_y ^ w_c[j];
      assign w_c[j+1] = (w_x & w_y) | (w_c[j] & (w_x ^ w_y));
    end
    assign w_row[i][4] = w_c[4];
  end
  assign o_p = {w_row[3][4:1], w_row[3][0], w_row[2][0], w_row[1][0], w_row[0][0]};
endmodule

module array_combine_8x8 (
  input logic clk,
  input logic rst,
  array_combine_8x8_if.slave bus
);
  logic [7:0]  w_ll, w_lh, w_hl, w_hh;
  logic [8:0]  w_m;
  logic [16:0] w_f;
  logic [16:0] r_r;
  logic        r_valid;
  array_mul4x4 u_ll (.i_a(bus.A[3:0]), .i_b(bus.B[3:0]), .o_p(w_ll));
  array_mul4x4 u_lh (.i_a(bus.A[3:0]), .i_b(bus.B[7:4]), .o_p(w_lh));
  array_mul4x4 u_hl (.i_a(bus.A[7:4]), .i_b(bus.B[3:0]), .o_p(w_hl));
  array_mul4x4 u_hh (.i_a(bus.A[7:4]), .i_b(bus.B[7:4]), .o_p(w_hh));
  assign w_m = {1'b0, w_lh} + {1'b0, w_hl};
`ifdef ARRAY_COMBINE_EXACT_EN
  logic [4:0] w_mid;
  assign w_mid = {1'b0, w_ll[7:4]} + {1'b0, w_m[3:0]};
  assign w_f = {{1'b0, w_hh} + {4'b0, w_m[8:4]} + {8'b0, w_mid[4]}, w_mid[3:0], w_ll[3:0]};
`else
  // OR instead of add in bits [7:4]: no carry ever reaches the upper sum
  assign w_f = {{1'b0, w_hh} + {4'b0, w_m[8:4]}, w_ll[7:4] | w_m[3:0], w_ll[3:0]};
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_r     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) r_r <= w_f;
    end
  end
  assign bus.R         = r_r;
  assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_array_combine_8x8.sv
// tb_array_combine_8x8: scoreboard bench comparing the multiplier against an arithmetic reference model.
module tb_array_combine_8x8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  array_combine_8x8_if bus ();
  array_combine_8x8 dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [16:0] r;
    int          p;
    string       tag;
  } exp_t;
  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [16:0] last_r = '0;

  function automatic logic [16:0] model(int a, int b);
    int ll, m, hh;
    ll = (a % 16) * (b % 16);
    m  = (a % 16) * (b / 16) + (a / 16) * (b % 16);
    hh = (a / 16) * (b / 16);
`ifdef ARRAY_COMBINE_EXACT_EN
    return 17'(a * b);
`else
    return 17'((ll % 16) + (((ll / 16) | (m % 16)) * 16) + ((hh + m / 16) * 256));
`endif
  endfunction

  task automatic cycle(bit r, bit v, int a, int b, string tag);
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.in_valid = v;
    bus.A = 8'(a);
    bus.B = 8'(b);
    if (r) last_r = '0;
    else if (v) last_r = model(a, b);
    e.v = !r && v;
    e.r = last_r;
    e.p = a * b;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic expect_const(bit v, int a, int b, logic [16:0] want, string tag);
    if (model(a, b) !== want) begin
      errors++;
      $display("FAIL model_%s: model gives %0d, required %0d", tag, model(a, b), want);
    end
    checks++;
    cycle(1'b0, v, a, b, tag);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (bus.out_valid !== e.v || bus.R !== e.r) begin
        errors++;
        $display("FAIL %s: got valid=%0b R=%0d, required valid=%0b R=%0d", e.tag, bus.out_valid, bus.R, e.v, e.r);
      end
      if (e.v) begin
        checks++;
        if (bus.R > 17'(e.p) || bus.R[16] !== 1'b0) begin
          errors++;
          $display("FAIL bound_%s: R=%0d exceeds product %0d or R[16] set", e.tag, bus.R, e.p);
        end
      end
    end
  end

  initial begin
    bus.in_valid = 1'b1;
    bus.A = 8'd255;
    bus.B = 8'd255;
    cycle(1'b1, 1'b1, 255, 255, "reset0");
    cycle(1'b1, 1'b1, 255, 255, "reset1");
    expect_const(1'b1, 0, 77, 17'd0, "zero");
    expect_const(1'b1, 3, 5, 17'd15, "3x5");
    expect_const(1'b1, 16, 16, 17'd256, "16x16");
    expect_const(1'b1, 17, 17, 17'd289, "17x17");
    expect_const(1'b1, 24, 24, 17'd576, "24x24");
`ifdef ARRAY_COMBINE_EXACT_EN
    expect_const(1'b1, 28, 28, 17'd784, "28x28");
    expect_const(1'b1, 255, 255, 17'd65025, "255x255");
`else
    expect_const(1'b1, 28, 28, 17'd656, "28x28");
    expect_const(1'b1, 255, 255, 17'd64993, "255x255");
`endif
    cycle(1'b0, 1'b0, 0, 0, "gap");
    cycle(1'b0, 1'b1, 3, 5, "stream0");
    cycle(1'b0, 1'b1, 17, 17, "stream1");
    cycle(1'b0, 1'b1, 28, 28, "stream2");
    cycle(1'b0, 1'b0, 200, 100, "hold0");
    cycle(1'b0, 1'b0, 9, 250, "hold1");
    cycle(1'b0, 1'b1, 99, 201, "pre_rst");
    cycle(1'b1, 1'b1, 123, 45, "mid_rst");
    cycle(1'b0, 1'b0, 7, 7, "post_rst");
    for (int i = 0; i < 2000; i++)
      cycle(1'b0, ($urandom_range(3) != 0), $urandom_range(255), $urandom_range(255), "random");
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 256; b++)
        cycle(1'b0, 1'b1, a, b, "exhaustive");
    cycle(1'b0, 1'b0, 0, 0, "final_hold");
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/array_combine_8x8.md
Name: array_combine_8x8

Overview:
- Registered 8x8 unsigned approximate multiplier using the carry-disregard scheme.
- Each operand is split into 4-bit nibbles. Four exact 4x4 array sub-multipliers produce partial products, which are then combined.
- One approximation: the carry chain between the low partial product and the middle sum is discarded in bits [7:4].
- Used as a low-area multiplier in error-tolerant datapaths. Result is 17 bits wide, consistent with the rest of the multiplier family.

Parameters:
- None. Operand width is fixed at 8 bits and result width at 17 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  A/B sampled on this cycle
- A  input  8  unsigned multiplicand
- B  input  8  unsigned multiplier
- out_valid  output  1  R holds the result of the operands sampled one cycle earlier
- R  output  17  approximate product, unsigned

Behaviour:
- Single clock domain. Reset is synchronous and active-high: on a rising clk edge with rst=1, R<=0 and out_valid<=0. rst takes priority over in_valid.
- Latency is 1 cycle. At a clk edge with in_valid=1 and rst=0:
  - R <= f(A,B), computed combinationally from the current A and B.
  - out_valid <= 1.
- At a clk edge with in_valid=0 and rst=0: out_valid <= 0 and R holds its previous value.
- No backpressure. One new operation is accepted every cycle. Back-to-back in_valid pulses produce back-to-back results.
- f(A,B), with AL=A[3:0], AH=A[7:4], BL=B[3:0], BH=B[7:4]:
  - LL=AL*BL, LH=AL*BH, HL=AH*BL, HH=AH*BH. Each is an exact 8-bit product from a 4x4 AND/full-adder array.
  - M = LH + HL, exact, 9 bits.
  - R[3:0] = LL[3:0].
  - R[7:4] = LL[7:4] | M[3:0]. This is the carry-disregard step: bitwise OR, and no carry propagates into bit 8.
  - R[16:8] = {1'b0,HH} + M[8:4], exact 9-bit sum. R[16] is structurally present but is 0 for every input (maximum 225+28=253).
- Result is exact whenever LL[7:4] & M[3:0] == 0. Otherwise R is at most the exact product.
- Operands of 0 give R=0 for any other operand.
- No internal state besides the output registers. Reset asserted mid-stream discards the in-flight result.

Optional Feature:
- Macro ARRAY_COMBINE_EXACT_EN.
- Defined: R[7:4] and the upper sum use a full carry chain, so R = A*B exactly (R[16]=0). The valid, reset and latency behaviour is unchanged.
- Undefined: the approximate OR combine described above is used. This is the default build.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, A=255, B=255 -> R=0 and out_valid=0 throughout. After release the first result appears 1 cycle later.
- Exact-region cases, in_valid=1: (0,77)->0; (3,5)->15; (16,16)->256; (17,17)->289; (24,24)->576. Each R appears on the cycle after sampling with out_valid=1.
- Approximation cases: (28,28)->656 (exact would be 784); (255,255)->64993 (0xFDE1, exact would be 65025). With ARRAY_COMBINE_EXACT_EN defined these give 784 and 65025.
- Streaming: in_valid high for 3 consecutive cycles with (3,5),(17,17),(28,28) -> R = 15, 289, 656 on consecutive cycles, out_valid high for 3 cycles then low.
- Hold: after a result, drop in_valid and change A/B -> out_valid=0 and R unchanged.
- Exhaustive: all 65536 (A,B) pairs checked against the golden formula f(A,B). In every case R<=A*B and R[16]=0.
